// File: rtl/cdb_arbiter_pkg.sv
// Shared writeback types: register/ROB index widths and the CDB packet that
// FU response ports and every CDB consumer agree on.
package cdb_arbiter_pkg;

  localparam int RV_XLEN         = 32;
  localparam int ARCH_REG_IDX    = 4;
  localparam int PHYS_REG_IDX    = 5;
  localparam int NUM_ROB_ENTRIES = 16;
  localparam int ROBW            = $clog2(NUM_ROB_ENTRIES);

  typedef struct packed {
    logic [RV_XLEN-1:0]      value;
    logic [ARCH_REG_IDX:0]   rd;
    logic [PHYS_REG_IDX:0]   pd;
    logic [ROBW-1:0]         rob_idx;
    logic                    dest_we;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Round-robin arbiter: the first request at or after ptr (wrapping) wins.
// Double-width masked priority encode, so no per-pointer rotate logic.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  always_comb begin
    dbl       = {req, req};
    masked    = '0;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int j = 0; j < 2*N; j++) begin
      masked[j] = dbl[j] && (j >= int'(ptr));
    end
    // Descending scan: the lowest masked bit is the last one written.
    for (int j = 2*N-1; j >= 0; j--) begin
      if (masked[j]) begin
        gnt       = '0;
        gnt[(j >= N) ? j - N : j] = 1'b1;
        gnt_idx   = IW'((j >= N) ? j - N : j);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback arbiter: grants one completed FU result per cycle, round-robin,
// and broadcasts it on a registered common data bus one cycle later.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int XLEN   = RV_XLEN,
  parameter  int NUM_FU = 4,
  localparam int SRCW   = $clog2(NUM_FU)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  input  logic [NUM_FU-1:0]                     fu_valid,
  output logic [NUM_FU-1:0]                     fu_ready,
  input  logic [NUM_FU-1:0][XLEN-1:0]           fu_value,
  input  logic [NUM_FU-1:0][ARCH_REG_IDX:0]     fu_rd,
  input  logic [NUM_FU-1:0][PHYS_REG_IDX:0]     fu_pd,
  input  logic [NUM_FU-1:0][ROBW-1:0]           fu_rob_idx,
  input  logic [NUM_FU-1:0]                     fu_dest_we,
  output logic                                  cdb_valid,
  output logic [XLEN-1:0]                       cdb_value,
  output logic [ARCH_REG_IDX:0]                 cdb_rd,
  output logic [PHYS_REG_IDX:0]                 cdb_pd,
  output logic [ROBW-1:0]                       cdb_rob_idx,
  output logic                                  cdb_dest_we,
  output logic [SRCW-1:0]                       cdb_src
);

  // Handshake: a result moves when fu_valid[i] && fu_ready[i] at a rising edge.
  // fu_ready is a combinational function of fu_valid, so FU valid/data must be
  // driven from flops; the FU holds its result until it sees its ready.

  localparam int PKT_W = $bits(cdb_pkt_t);

  logic [NUM_FU-1:0] req;
  logic [NUM_FU-1:0] gnt;
  logic [SRCW-1:0]   gnt_idx;
  logic              gnt_valid;
  logic [SRCW-1:0]   rr_ptr;
  logic [SRCW-1:0]   next_ptr;
  logic [PKT_W-1:0]  sel_bits;
  cdb_pkt_t          fu_pkt [NUM_FU];
  cdb_pkt_t          cdb_q;

  // Flush and reset both suppress every grant so no FU is popped.
  assign req = fu_valid & {NUM_FU{~flush & rst_n}};

  rr_arbiter #(.N(NUM_FU)) u_rr (
    .req       (req),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign fu_ready = gnt;
  assign next_ptr = (gnt_idx == SRCW'(NUM_FU-1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    sel_bits = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_pkt[i] = '{value: fu_value[i], rd: fu_rd[i], pd: fu_pd[i],
                    rob_idx: fu_rob_idx[i], dest_we: fu_dest_we[i]};
      sel_bits  = sel_bits | (fu_pkt[i] & {PKT_W{gnt[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_q     <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
    end else if (gnt_valid) begin
      rr_ptr    <= next_ptr;
      cdb_valid <= 1'b1;
      cdb_q     <= cdb_pkt_t'(sel_bits);
      cdb_src   <= gnt_idx;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

  assign cdb_value   = cdb_q.value;
  assign cdb_rd      = cdb_q.rd;
  assign cdb_pd      = cdb_q.pd;
  assign cdb_rob_idx = cdb_q.rob_idx;
  assign cdb_dest_we = cdb_q.dest_we;

endmodule
